// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
package mult_div_pkg;

  // Default operand width; HI and LO are each this wide.
  localparam int DEFAULT_WIDTH = 32;

  // Operation select encodings driven by the control unit.
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// The partial remainder is always below the divisor, so it fits in WIDTH
// bits; only the shifted trial value needs the extra bit.
module div_restore_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Shift the next dividend bit in, trial-subtract, and keep or restore.
  always_comb begin
    shifted_s = {rem_in, quo_in[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, divisor};
    if (trial_s[WIDTH] == 1'b0) begin
      rem_out = trial_s[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit that
// produces a 2*WIDTH-bit result into HI/LO over WIDTH cycles.
// The Booth accumulator/multiplier registers double as remainder/quotient
// registers during a divide, and the multiplicand register holds |divisor|.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1] == 1'b1) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r,    state_s;
  logic [CW-1:0]    count_r,    count_s;
  logic [WIDTH:0]   acc_r,      acc_s;
  logic [WIDTH-1:0] q_r,        q_s;
  logic             qm1_r,      qm1_s;
  logic [WIDTH-1:0] m_r,        m_s;
  logic             sa_r,       sa_s;
  logic             sb_r,       sb_s;
  logic [WIDTH-1:0] hi_r,       hi_s;
  logic [WIDTH-1:0] lo_r,       lo_s;
  logic             busy_r,     busy_s;
  logic             done_r,     done_s;
  logic             div_zero_r, div_zero_s;

  logic [WIDTH:0]   m_ext_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc_r[WIDTH-1:0]),
    .quo_in  (q_r),
    .divisor (m_r),
    .rem_out (div_rem_s),
    .quo_out (div_quo_s)
  );

  // Booth add/subtract selected by the {Q0, Q(-1)} pair.
  always_comb begin
    m_ext_s = {m_r[WIDTH-1], m_r};
    case ({q_r[0], qm1_r})
      2'b01:   booth_sum_s = acc_r + m_ext_s;
      2'b10:   booth_sum_s = acc_r - m_ext_s;
      default: booth_sum_s = acc_r;
    endcase
  end

  // Sign fix-up of the final divide step: quotient by sign difference,
  // remainder follows the dividend.
  always_comb begin
    if ((sa_r ^ sb_r) == 1'b1) begin
      quo_fix_s = -div_quo_s;
    end else begin
      quo_fix_s = div_quo_s;
    end
    if (sa_r == 1'b1) begin
      rem_fix_s = -div_rem_s;
    end else begin
      rem_fix_s = div_rem_s;
    end
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    acc_s      = acc_r;
    q_s        = q_r;
    qm1_s      = qm1_r;
    m_s        = m_r;
    sa_s       = sa_r;
    sb_s       = sb_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    div_zero_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (start == 1'b1) begin
          if (op == OP_MULT) begin
            m_s     = a_in;
            acc_s   = '0;
            q_s     = b_in;
            qm1_s   = 1'b0;
            count_s = CW'(WIDTH);
            busy_s  = 1'b1;
            state_s = MULT;
          end else if (b_in == '0) begin
            // Rejected divide: report immediately, leave HI/LO alone.
            done_s     = 1'b1;
            div_zero_s = 1'b1;
          end else begin
            m_s     = abs_val(b_in);
            q_s     = abs_val(a_in);
            sa_s    = a_in[WIDTH-1];
            sb_s    = b_in[WIDTH-1];
            acc_s   = '0;
            count_s = CW'(WIDTH);
            busy_s  = 1'b1;
            state_s = DIV;
          end
        end else begin
          busy_s = 1'b0;
        end
      end

      MULT: begin
        acc_s   = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
        q_s     = {booth_sum_s[0], q_r[WIDTH-1:1]};
        qm1_s   = q_r[0];
        count_s = count_r - CW'(1);
        if (count_r == CW'(1)) begin
          hi_s    = acc_s[WIDTH-1:0];
          lo_s    = q_s;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          busy_s = 1'b1;
        end
      end

      DIV: begin
        acc_s   = {1'b0, div_rem_s};
        q_s     = div_quo_s;
        count_s = count_r - CW'(1);
        if (count_r == CW'(1)) begin
          hi_s    = rem_fix_s;
          lo_s    = quo_fix_s;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          busy_s = 1'b1;
        end
      end

      default: begin
        busy_s  = 1'b0;
        count_s = '0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      count_r    <= '0;
      acc_r      <= '0;
      q_r        <= '0;
      qm1_r      <= 1'b0;
      m_r        <= '0;
      sa_r       <= 1'b0;
      sb_r       <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      acc_r      <= acc_s;
      q_r        <= q_s;
      qm1_r      <= qm1_s;
      m_r        <= m_s;
      sa_r       <= sa_s;
      sb_r       <= sb_s;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      div_zero_r <= div_zero_s;
    end
  end

  assign hi_out   = hi_r;
  assign lo_out   = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Present one start pulse, sampled at the next rising edge; returns #1 after it.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; a_in = 32'h0; b_in = 32'h0;
  endtask

  // Count edges until done is seen (bounded at 40).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; a_in = 32'h0; b_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi_out, 32'h0); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", lo_out, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_divzero: got %b expected 0", div_zero); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    int cyc;
    // 7 * -3 = -21
    issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_start: got %b expected 1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL mult_latency: got %0d expected 32", cyc); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_7x-3_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
    checks++; if (lo_out !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_7x-3_lo: got %h expected %h", lo_out, 32'hFFFF_FFEB); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b expected 0", busy); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL mult_divzero: got %b expected 0", div_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
    // most negative squared
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc);
    checks++; if (hi_out !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi: got %h expected %h", hi_out, 32'h4000_0000); end
    checks++; if (lo_out !== 32'h0000_0000) begin errors++; $display("FAIL mult_min_lo: got %h expected %h", lo_out, 32'h0); end
    // -1 * -1 = 1
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    checks++; if (hi_out !== 32'h0000_0000) begin errors++; $display("FAIL mult_m1_hi: got %h expected %h", hi_out, 32'h0); end
    checks++; if (lo_out !== 32'h0000_0001) begin errors++; $display("FAIL mult_m1_lo: got %h expected %h", lo_out, 32'h1); end
    // 2^16 * 2^16 = 2^32
    issue(1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    checks++; if (hi_out !== 32'h0000_0001) begin errors++; $display("FAIL mult_2p32_hi: got %h expected %h", hi_out, 32'h1); end
    checks++; if (lo_out !== 32'h0000_0000) begin errors++; $display("FAIL mult_2p32_lo: got %h expected %h", lo_out, 32'h0); end
  endtask

  task automatic test_div;
    int cyc;
    // -7 / 2 = -3 rem -1
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_start: got %b expected 1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL div_latency: got %0d expected 32", cyc); end
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_lo: got %h expected %h", lo_out, 32'hFFFF_FFFD); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_divzero: got %b expected 0", div_zero); end
    // overflow wraps
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    checks++; if (lo_out !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", lo_out, 32'h8000_0000); end
    checks++; if (hi_out !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", hi_out, 32'h0); end
    // 100 / 7 = 14 rem 2
    issue(1'b1, 32'd100, 32'd7);
    wait_done(cyc);
    checks++; if (lo_out !== 32'd14) begin errors++; $display("FAIL div_100_7_lo: got %h expected %h", lo_out, 32'd14); end
    checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL div_100_7_hi: got %h expected %h", hi_out, 32'd2); end
    // 7 / -2 = -3 rem 1
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done(cyc);
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_lo: got %h expected %h", lo_out, 32'hFFFF_FFFD); end
    checks++; if (hi_out !== 32'h0000_0001) begin errors++; $display("FAIL div_7_m2_hi: got %h expected %h", hi_out, 32'h1); end
  endtask

  task automatic test_div_zero;
    // HI/LO hold 1 / 0xFFFFFFFD from the previous divide
    issue(1'b1, 32'd5, 32'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done: got %b expected 1", done); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse: got done=%b dz=%b expected 0 0", done, div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy_after: got %b expected 0", busy); end
    checks++; if (hi_out !== 32'h0000_0001) begin errors++; $display("FAIL dz_hi_kept: got %h expected %h", hi_out, 32'h1); end
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL dz_lo_kept: got %h expected %h", lo_out, 32'hFFFF_FFFD); end
  endtask

  task automatic test_back_to_back;
    int k;
    int cyc;
    issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    k = 1;
    while (done !== 1'b1 && k <= 40) begin
      @(negedge clk);
      if (k == 5 || k == 20) begin
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done !== 1'b1) k++;
    end
    checks++; if (k !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", k); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL b2b_divzero: got %b expected 0", div_zero); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
    checks++; if (lo_out !== 32'hFFFF_FFEB) begin errors++; $display("FAIL b2b_lo: got %h expected %h", lo_out, 32'hFFFF_FFEB); end
    // new start held during the done cycle is accepted
    start = 1'b1; op = 1'b0; a_in = 32'h0001_0000; b_in = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL b2b_latency2: got %0d expected 32", cyc); end
    checks++; if (hi_out !== 32'h0000_0001 || lo_out !== 32'h0) begin errors++; $display("FAIL b2b_result2: got %h_%h expected 00000001_00000000", hi_out, lo_out); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    issue(1'b1, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin errors++; $display("FAIL rstmid_hilo: got %h_%h expected 0_0", hi_out, lo_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
